// File: rtl/mul_pipe.sv
// mul_pipe: pipelined radix-4 Booth / carry-save integer multiplier with valid/ready flow control,
// selectable product half and flush. Only the low 2*WIDTH product bits are ever formed.
module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             mul_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int N  = (WIDTH + 2) / 2;
    localparam int XW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;

    logic adv, take, sx, sy;
    logic [XW-1:0] xe, ye;
    logic [XW:0] yb;
    logic [PW-1:0] xs, m, r, neg_row, s_c, c_c;
    logic [2:0] g;
    logic neg;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign take     = in_valid & adv & ~flush;

    assign sx = in_op[0];
    assign sy = in_op == 2'b01;
    assign xe = {{2{sx & in_x[WIDTH-1]}}, in_x};
    assign ye = {{2{sy & in_y[WIDTH-1]}}, in_y};
    assign yb = {ye, 1'b0};
    assign xs = {{(PW-XW){xe[XW-1]}}, xe};

    // Booth digits select 0/+-x/+-2x; negation is one's complement plus a bit in neg_row
    always_comb begin
        s_c     = '0;
        c_c     = '0;
        neg_row = '0;
        g       = '0;
        neg     = 1'b0;
        m       = '0;
        r       = '0;
        for (int i = 0; i < N; i++) begin
            g   = yb[2*i +: 3];
            neg = g[2] & ~(g[1] & g[0]);
            m   = (g[1] ^ g[0]) ? xs : (g == 3'b011 || g == 3'b100) ? (xs << 1) : '0;
            r   = (neg ? ~m : m) << (2 * i);
            neg_row[2*i] = neg;
            {s_c, c_c} = {s_c ^ c_c ^ r, ((s_c & c_c) | (s_c & r) | (c_c & r)) << 1};
        end
        {s_c, c_c} = {s_c ^ c_c ^ neg_row, ((s_c & c_c) | (s_c & neg_row) | (c_c & neg_row)) << 1};
    end

    logic [PW-1:0] fs, fc, prod;
    logic [1:0] fop;
    logic [TAG_W-1:0] ftag;
    logic fv;

    generate
        if (STAGES == 1) begin : g_direct
            assign fs   = s_c;
            assign fc   = c_c;
            assign fop  = in_op;
            assign ftag = in_tag;
            assign fv   = take;
        end else begin : g_rows
            logic [PW-1:0] s_q [STAGES-1];
            logic [PW-1:0] c_q [STAGES-1];
            logic [1:0] op_q [STAGES-1];
            logic [TAG_W-1:0] tag_q [STAGES-1];
            logic [STAGES-2:0] v_q;
            always_ff @(posedge mul_clk or posedge reset) begin
                if (reset) v_q <= '0;
                else if (flush) v_q <= '0;
                else if (adv) begin
                    for (int i = STAGES - 2; i > 0; i--) v_q[i] <= v_q[i-1];
                    v_q[0] <= take;
                end
            end
            always_ff @(posedge mul_clk) begin
                if (adv) begin
                    for (int i = STAGES - 2; i > 0; i--) begin
                        s_q[i]   <= s_q[i-1];
                        c_q[i]   <= c_q[i-1];
                        op_q[i]  <= op_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                    s_q[0]   <= s_c;
                    c_q[0]   <= c_c;
                    op_q[0]  <= in_op;
                    tag_q[0] <= in_tag;
                end
            end
            assign fs   = s_q[STAGES-2];
            assign fc   = c_q[STAGES-2];
            assign fop  = op_q[STAGES-2];
            assign ftag = tag_q[STAGES-2];
            assign fv   = v_q[STAGES-2];
        end
    endgenerate

    assign prod = fs + fc;

    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (flush) out_valid <= 1'b0;
            else if (adv) out_valid <= fv;
            if (adv) begin
                out_result <= (fop == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
                out_tag    <= ftag;
            end
        end
    end
endmodule
